// File: rtl/adder_pkg.sv
// Shared constants for the pipelined ripple-carry adder.
//   DEF_WIDTH  : default operand/sum width
//   DEF_STAGES : default pipeline depth
//   OP_ADD/SUB : encoding of the 'sub' mode input
package adder_pkg;
    localparam int   DEF_WIDTH  = 32;
    localparam int   DEF_STAGES = 4;
    localparam logic OP_ADD     = 1'b0;
    localparam logic OP_SUB     = 1'b1;
endpackage

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple-carry adder built from per-bit full adders.
//   a, b : segment operands
//   cin  : carry into bit 0
//   sum  : segment sum
//   cout : carry out of the top bit
module rca_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);
    logic [SEG:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SEG];
endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor. Stage k adds operand bits
// [k*SEG +: SEG] using the carry registered by stage k-1; operands and the
// partial sum travel alongside in skew registers. Global stall: every
// register advances only when the output slot is free or being consumed.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready = advance enable)
//   a, b, cin, sub      : operands, carry-in (add only), mode (1 = a - b)
//   out_valid/out_ready : output handshake
//   sum_r, cout_r, ovf_r: registered sum, carry-out, signed overflow
module pipelined_rca_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_r,
    output logic             cout_r,
    output logic             ovf_r
);
    localparam int SEG = WIDTH / STAGES;

    logic             en;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Register row k holds the state after stage k has added its segment.
    logic [STAGES-1:0]            vld_pipe;
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [STAGES-1:0]            c_q;
    logic                         ovf_q;

    // Combinational view of each stage: inputs and freshly computed values.
    logic [STAGES-1:0][WIDTH-1:0] st_a, st_b, st_s, nxt_s;
    logic [STAGES-1:0]            st_c, nxt_c;
    logic                         ovf_nxt;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // Subtraction is a + ~b + 1; the caller's cin only matters for add.
    assign b_eff   = (sub == OP_SUB) ? ~b : b;
    assign cin_eff = (sub == OP_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0] seg_sum;

        if (k == 0) begin : g_first
            assign st_a[k] = a;
            assign st_b[k] = b_eff;
            assign st_s[k] = '0;
            assign st_c[k] = cin_eff;
        end else begin : g_rest
            assign st_a[k] = a_q[k-1];
            assign st_b[k] = b_q[k-1];
            assign st_s[k] = s_q[k-1];
            assign st_c[k] = c_q[k-1];
        end

        rca_segment #(.SEG(SEG)) u_seg (
            .a    (st_a[k][k*SEG +: SEG]),
            .b    (st_b[k][k*SEG +: SEG]),
            .cin  (st_c[k]),
            .sum  (seg_sum),
            .cout (nxt_c[k])
        );

        // Bits of segment k in the partial sum are still zero here, so an OR
        // is enough to merge the new segment in.
        assign nxt_s[k] = st_s[k] | (WIDTH'(seg_sum) << (k * SEG));
    end

    assign ovf_nxt = (st_a[STAGES-1][WIDTH-1] == st_b[STAGES-1][WIDTH-1]) &&
                     (nxt_s[STAGES-1][WIDTH-1] != st_a[STAGES-1][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
        end else if (en) begin
            vld_pipe[0] <= accept;
            for (int k = 1; k < STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= st_a[k];
                b_q[k] <= st_b[k];
                s_q[k] <= nxt_s[k];
                c_q[k] <= nxt_c[k];
            end
            ovf_q <= ovf_nxt;
        end
    end

    assign out_valid = vld_pipe[STAGES-1];
    assign sum_r     = s_q[STAGES-1];
    assign cout_r    = c_q[STAGES-1];
    assign ovf_r     = ovf_q;

    // Operand skew of the last row has no consumer downstream.
    logic unused;
    assign unused = ^{a_q[STAGES-1], b_q[STAGES-1]};
endmodule

// File: tb/tb_pipelined_rca_adder.sv
module tb_pipelined_rca_adder;
    import adder_pkg::*;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endfunction

    function automatic exp_t mk(logic [31:0] s, logic c, logic o);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o;
        return e;
    endfunction

    // Reference model for random traffic: plain wide arithmetic on w bits.
    function automatic exp_t model(int w, logic [31:0] va, logic [31:0] vb, logic vc, logic vs);
        logic [32:0] mask, full, ax, bx;
        exp_t e;
        mask = (33'd1 << w) - 33'd1;
        ax   = {1'b0, va} & mask;
        bx   = (vs ? {1'b0, ~vb} : {1'b0, vb}) & mask;
        full = ax + bx + 33'(vs ? 1'b1 : vc);
        e.sum  = full[31:0] & mask[31:0];
        e.cout = full[w];
        e.ovf  = (ax[w-1] == bx[w-1]) && (full[w-1] != ax[w-1]);
        return e;
    endfunction

    // ---------------- main DUT: 32 bits, 4 stages ----------------
    logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout_r, ovf_r;
    logic [31:0] a, b, sum_r;

    pipelined_rca_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_r(sum_r), .cout_r(cout_r), .ovf_r(ovf_r)
    );

    // ---------------- 8 bits, 1 stage ----------------
    logic       v8, ir8, c8, s8, ov8, or8, co8, of8;
    logic [7:0] a8, b8, sum8;

    pipelined_rca_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(c8), .sub(s8),
        .out_valid(ov8), .out_ready(or8),
        .sum_r(sum8), .cout_r(co8), .ovf_r(of8)
    );

    // ------- 32x32 and 16x2 sharing one random input stream -------
    logic        rv, rc, rs, rrdy;
    logic [31:0] ra, rb;
    logic        ir32, ov32, co32, of32, ir16, ov16, co16, of16;
    logic [31:0] sum32;
    logic [15:0] sum16;

    pipelined_rca_adder #(.WIDTH(32), .STAGES(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(rv), .in_ready(ir32),
        .a(ra), .b(rb), .cin(rc), .sub(rs),
        .out_valid(ov32), .out_ready(rrdy),
        .sum_r(sum32), .cout_r(co32), .ovf_r(of32)
    );

    pipelined_rca_adder #(.WIDTH(16), .STAGES(2)) dut16 (
        .clk(clk), .rst(rst), .in_valid(rv), .in_ready(ir16),
        .a(ra[15:0]), .b(rb[15:0]), .cin(rc), .sub(rs),
        .out_valid(ov16), .out_ready(rrdy),
        .sum_r(sum16), .cout_r(co16), .ovf_r(of16)
    );

    exp_t q1[$];
    exp_t q32[$];
    exp_t q16[$];

    // ---------------- monitors ----------------
    logic        prev_stall = 1'b0;
    logic [31:0] ps;
    logic        pc, po;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_sum", sum_r, ps);
                chk("hold_cout", cout_r, pc);
                chk("hold_ovf", ovf_r, po);
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                prev_stall <= 1'b1;
                ps <= sum_r; pc <= cout_r; po <= ovf_r;
            end else begin
                prev_stall <= 1'b0;
            end
            if (out_valid && out_ready) begin
                if (q1.size() == 0) fail_now("unexpected_out");
                else begin
                    e = q1.pop_front();
                    chk("sum", sum_r, e.sum);
                    chk("cout", cout_r, e.cout);
                    chk("ovf", ovf_r, e.ovf);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov32 && rrdy) begin
            if (q32.size() == 0) fail_now("unexpected_out32");
            else begin
                e = q32.pop_front();
                chk("sum32", {sum32, co32, of32}, {e.sum, e.cout, e.ovf});
            end
        end
        if (!rst && ov16 && rrdy) begin
            if (q16.size() == 0) fail_now("unexpected_out16");
            else begin
                e = q16.pop_front();
                chk("sum16", {sum16, co16, of16}, {e.sum[15:0], e.cout, e.ovf});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [31:0] va, input logic [31:0] vb,
                        input logic vc, input logic vs, input exp_t e);
        int  n = 0;
        bit  done = 1'b0;
        a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                q1.push_back(e);
                done = 1'b1;
            end else if (++n > 50) begin
                fail_now("send_timeout");
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain1();
        int n = 0;
        while (q1.size() != 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_q1", q1.size(), 0);
    endtask

    task automatic drive8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input logic vs, input logic [7:0] es, input logic ec, input logic eo);
        a8 = va; b8 = vb; c8 = vc; s8 = vs; v8 = 1'b1;
        chk("in_ready8", ir8, 1);
        @(posedge clk); #1;
        v8 = 1'b0;
        chk("valid8", ov8, 1);
        chk("sum8", sum8, es);
        chk("cout8", co8, ec);
        chk("ovf8", of8, eo);
    endtask

    // Back-to-back stream with a mid-stream stall, hand-computed results.
    logic [31:0] va[8] = '{32'h1, 32'h10, 32'h80000000, 32'hA, 32'hFFFF, 32'h0, 32'h80000000, 32'h12345678};
    logic [31:0] vb[8] = '{32'h2, 32'h20, 32'h80000000, 32'h3, 32'h1,    32'h1, 32'h1,        32'h11111111};
    logic        vc[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    logic        vs[8] = '{0, 0, 0, 1, 0, 1, 1, 0};
    logic [31:0] es[8] = '{32'h3, 32'h30, 32'h0, 32'h7, 32'h10001, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h23456789};
    logic        ec[8] = '{0, 0, 1, 1, 0, 0, 1, 0};
    logic        eo[8] = '{0, 0, 1, 0, 0, 0, 1, 0};

    bit rnd_done;

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = OP_ADD; out_ready = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; s8 = 1'b0; or8 = 1'b1;
        rv = 1'b0; ra = '0; rb = '0; rc = 1'b0; rs = 1'b0; rrdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum_r, 0);
        chk("rst_cout", cout_r, 0);
        chk("rst_ovf", ovf_r, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid8", ov8, 0);

        // carry ripples through all four segments; check latency
        send(32'hFFFFFFFF, 32'h1, 1'b0, OP_ADD, mk(32'h0, 1'b1, 1'b0));
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", n, 4);
        drain1();

        send(32'h5, 32'h7, 1'b0, OP_SUB, mk(32'hFFFFFFFE, 1'b0, 1'b0));
        send(32'h5, 32'h7, 1'b1, OP_SUB, mk(32'hFFFFFFFE, 1'b0, 1'b0));
        send(32'h7FFFFFFF, 32'h1, 1'b0, OP_ADD, mk(32'h80000000, 1'b0, 1'b1));
        drain1();

        // back-to-back with a 3-cycle output stall
        fork
            begin
                for (int i = 0; i < 8; i++) send(va[i], vb[i], vc[i], vs[i], mk(es[i], ec[i], eo[i]));
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain1();

        // reset with three transactions in flight
        for (int i = 0; i < 3; i++) send(va[i], vb[i], vc[i], vs[i], mk(es[i], ec[i], eo[i]));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q1.delete();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        repeat (10) @(posedge clk);
        #1;

        // single-stage 8-bit instance
        drive8(8'hC8, 8'h64, 1'b1, OP_ADD, 8'h2D, 1'b1, 1'b0);
        drive8(8'h10, 8'h20, 1'b0, OP_SUB, 8'hF0, 1'b0, 1'b0);
        drive8(8'h7F, 8'h01, 1'b0, OP_ADD, 8'h80, 1'b0, 1'b1);

        // random traffic on the main instance with random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    logic [31:0] x, y;
                    logic        c, s;
                    x = $urandom; y = $urandom; c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
                    if (i % 7 == 0) y = x;
                    send(x, y, c, s, model(32, x, y, c, s));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain1();

        // random stream into the 32x32 and 16x2 instances
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            rv = ($urandom_range(0, 3) != 0);
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rv && ir32) q32.push_back(model(32, ra, rb, rc, rs));
            if (rv && ir16) q16.push_back(model(16, ra, rb, rc, rs));
        end
        @(posedge clk); #1;
        rv = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("drain_q32", q32.size(), 0);
        chk("drain_q16", q16.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
